// File: rtl/boot_supervisor.sv
// Bootloader housekeeping: us/ms/step ticks, breathing LED, host SOF watchdog and sticky warm-boot request.
// Optional build macro BOOT_SUPERVISOR_STATUS_LED_EN makes the LED show supervisor state instead of always breathing.
module boot_supervisor #(
    parameter int CLK_FREQ_HZ  = 48000000,
    parameter int PWM_BITS     = 8,
    parameter int STEP_US      = 1000,
    parameter int TIMEOUT_MS   = 1000,
    parameter int NUM_BOOT_SRC = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sof_valid,
    input  logic [NUM_BOOT_SRC-1:0] boot_req,
    input  logic                    inhibit,
    output logic                    led,
    output logic                    boot,
    output logic                    timeout,
    output logic [1:0]              state
);
    // state     | meaning
    // WAIT_HOST | no SOF seen yet, watchdog running
    // CONNECTED | host sending SOFs, watchdog re-armed by each one
    // ARMED     | boot decided, held off while flash is busy
    // BOOT      | warm-boot requested, terminal until reset
    typedef enum logic [1:0] {
        WAIT_HOST = 2'd0,
        CONNECTED = 2'd1,
        ARMED     = 2'd2,
        BOOT      = 2'd3
    } state_t;

    localparam int PRESC = CLK_FREQ_HZ / 1000000;
    localparam int PW    = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int SW    = (STEP_US > 1) ? $clog2(STEP_US) : 1;
    localparam int TW    = $clog2(TIMEOUT_MS + 1);

    localparam logic [PW-1:0]       PRESC_LAST = PW'(PRESC - 1);
    localparam logic [SW-1:0]       STEP_LAST  = SW'(STEP_US - 1);
    localparam logic [TW-1:0]       TIMER_MAX  = TW'(TIMEOUT_MS);
    localparam logic [PWM_BITS-1:0] BRIGHT_MAX = {PWM_BITS{1'b1}};

    logic [PW-1:0]       presc_q, presc_d;
    logic [9:0]          us_cnt_q, us_cnt_d;
    logic [SW-1:0]       step_cnt_q, step_cnt_d;
    logic [PWM_BITS-1:0] bright_q, bright_d;
    logic                dir_up_q, dir_up_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                led_breathe_q, led_breathe_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                us_tick, ms_tick, step_tick, expired;

    state_t state_q;
    logic   boot_q, timeout_q;

    always_comb begin
        us_tick    = (presc_q == PRESC_LAST);
        ms_tick    = us_tick && (us_cnt_q == 10'd999);
        step_tick  = us_tick && (step_cnt_q == STEP_LAST);
        expired    = (timer_q == TIMER_MAX);

        presc_d    = us_tick ? '0 : presc_q + 1'b1;
        us_cnt_d   = us_cnt_q;
        step_cnt_d = step_cnt_q;
        if (us_tick) begin
            us_cnt_d   = (us_cnt_q == 10'd999) ? '0 : us_cnt_q + 1'b1;
            step_cnt_d = (step_cnt_q == STEP_LAST) ? '0 : step_cnt_q + 1'b1;
        end

        // Triangle: the turnaround step holds the extreme value for one extra step.
        bright_d = bright_q;
        dir_up_d = dir_up_q;
        if (step_tick) begin
            if (dir_up_q) begin
                if (bright_q == BRIGHT_MAX) dir_up_d = 1'b0;
                else                        bright_d = bright_q + 1'b1;
            end else begin
                if (bright_q == '0) dir_up_d = 1'b1;
                else                bright_d = bright_q - 1'b1;
            end
        end

        pwm_cnt_d     = pwm_cnt_q + 1'b1;
        led_breathe_d = (bright_q > pwm_cnt_q);

        timer_d = timer_q;
        if (sof_valid)                timer_d = '0;
        else if (ms_tick && !expired) timer_d = timer_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q       <= '0;
            us_cnt_q      <= '0;
            step_cnt_q    <= '0;
            bright_q      <= '0;
            dir_up_q      <= 1'b1;
            pwm_cnt_q     <= '0;
            led_breathe_q <= 1'b0;
            timer_q       <= '0;
        end else begin
            presc_q       <= presc_d;
            us_cnt_q      <= us_cnt_d;
            step_cnt_q    <= step_cnt_d;
            bright_q      <= bright_d;
            dir_up_q      <= dir_up_d;
            pwm_cnt_q     <= pwm_cnt_d;
            led_breathe_q <= led_breathe_d;
            timer_q       <= timer_d;
        end
    end

    // A boot request or expiry outranks a coincident SOF so a request is never dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= WAIT_HOST;
            boot_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                WAIT_HOST, CONNECTED: begin
                    if (expired || (|boot_req)) begin
                        state_q <= ARMED;
                        if (expired) timeout_q <= 1'b1;
                    end else if (sof_valid) begin
                        state_q <= CONNECTED;
                    end
                end
                ARMED: begin
                    if (!inhibit) begin
                        state_q <= BOOT;
                        boot_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= BOOT;
                    boot_q  <= 1'b1;
                end
            endcase
        end
    end

`ifdef BOOT_SUPERVISOR_STATUS_LED_EN
    logic [9:0] blink_cnt_q, blink_cnt_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        if (ms_tick) blink_cnt_d = (blink_cnt_q == 10'd999) ? '0 : blink_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) blink_cnt_q <= '0;
        else       blink_cnt_q <= blink_cnt_d;
    end

    always_comb begin
        case (state_q)
            WAIT_HOST: led = (blink_cnt_q < 10'd500);
            CONNECTED: led = led_breathe_q;
            default:   led = 1'b0;
        endcase
    end
`else
    assign led = led_breathe_q;
`endif

    assign boot    = boot_q;
    assign timeout = timeout_q;
    assign state   = state_q;
endmodule

// File: tb/tb_boot_supervisor.sv
// Directed bench for boot_supervisor at 4 MHz, 3-bit PWM, 2 us steps, 3 ms timeout.
module tb_boot_supervisor;
    logic       clk = 1'b0;
    logic       reset;
    logic       sof_valid;
    logic [1:0] boot_req;
    logic       inhibit;
    logic       led, boot, timeout;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    boot_supervisor #(
        .CLK_FREQ_HZ (4000000),
        .PWM_BITS    (3),
        .STEP_US     (2),
        .TIMEOUT_MS  (3),
        .NUM_BOOT_SRC(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sof_valid(sof_valid),
        .boot_req (boot_req),
        .inhibit  (inhibit),
        .led      (led),
        .boot     (boot),
        .timeout  (timeout),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    int mbright;
    int mup;
    int led_cnt;

    initial begin
        reset     = 1'b1;
        sof_valid = 1'b0;
        boot_req  = 2'b00;
        inhibit   = 1'b0;
        repeat (3) tick();
        check("rst_state",   32'(state),   32'd0);
        check("rst_led",     32'(led),     32'd0);
        check("rst_boot",    32'(boot),    32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);

        // Free run with no host: ticks, breathing, then timeout and boot.
        reset   = 1'b0;
        mbright = 0;
        mup     = 1;
        led_cnt = 0;
        for (int n = 1; n <= 12002; n++) begin
            tick();
            if (n <= 40) begin
                check("us_tick",   32'(dut.us_tick),   32'((n % 4) == 3));
                check("step_tick", 32'(dut.step_tick), 32'((n % 8) == 7));
            end
            if (n <= 200) begin
                led_cnt += int'(led);
                if ((n % 8) == 0) begin
                    check("led_duty", 32'(led_cnt), 32'(mbright));
                    led_cnt = 0;
                    if (mup == 1) begin
                        if (mbright < 7) mbright++;
                        else             mup = 0;
                    end else begin
                        if (mbright > 0) mbright--;
                        else             mup = 1;
                    end
                    check("bright", 32'(dut.bright_q), 32'(mbright));
                end
            end
            if (n == 3998) check("ms_tick_pre", 32'(dut.ms_tick), 32'd0);
            if (n == 3999) check("ms_tick_1",   32'(dut.ms_tick), 32'd1);
            if (n == 7999) check("ms_tick_2",   32'(dut.ms_tick), 32'd1);
            if (n == 12000) begin
                check("to_state_before", 32'(state),   32'd0);
                check("to_flag_before",  32'(timeout), 32'd0);
            end
            if (n == 12001) begin
                check("to_state_armed", 32'(state),   32'd2);
                check("to_flag",        32'(timeout), 32'd1);
                check("to_boot_armed",  32'(boot),    32'd0);
            end
            if (n == 12002) begin
                check("to_state_boot", 32'(state),   32'd3);
                check("to_boot",       32'(boot),    32'd1);
                check("to_flag_stick", 32'(timeout), 32'd1);
            end
        end

        // Reset while in BOOT returns everything to power-on values.
        reset = 1'b1;
        tick();
        check("mid_rst_boot",    32'(boot),    32'd0);
        check("mid_rst_timeout", 32'(timeout), 32'd0);
        check("mid_rst_state",   32'(state),   32'd0);
        check("mid_rst_led",     32'(led),     32'd0);

        // Keepalive: SOF on every ms_tick cycle for 10 ms.
        reset = 1'b0;
        for (int n = 1; n <= 40000; n++) begin
            tick();
            sof_valid = ((n % 4000) == 3999);
            if (n == 4000) begin
                check("ka_connected", 32'(state),       32'd1);
                check("ka_clear_win", 32'(dut.timer_q), 32'd0);
            end
            if (n == 20000) check("ka_mid_timeout", 32'(timeout), 32'd0);
        end
        check("ka_state",   32'(state),       32'd1);
        check("ka_boot",    32'(boot),        32'd0);
        check("ka_timeout", 32'(timeout),     32'd0);
        check("ka_timer",   32'(dut.timer_q), 32'd0);
        sof_valid = 1'b0;

        // Boot request from CONNECTED with flash idle.
        boot_req = 2'b01;
        tick();
        boot_req = 2'b00;
        check("req_conn_armed",   32'(state),   32'd2);
        check("req_conn_timeout", 32'(timeout), 32'd0);
        tick();
        check("req_conn_boot", 32'(boot), 32'd1);

        // Boot request deferred by inhibit.
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        inhibit = 1'b1;
        repeat (2) tick();
        check("inh_idle", 32'(state), 32'd0);
        boot_req = 2'b10;
        tick();
        boot_req = 2'b00;
        check("inh_armed",      32'(state), 32'd2);
        check("inh_boot_armed", 32'(boot),  32'd0);
        repeat (5) tick();
        check("inh_hold_state", 32'(state), 32'd2);
        check("inh_hold_boot",  32'(boot),  32'd0);
        inhibit = 1'b0;
        tick();
        check("inh_release_state", 32'(state), 32'd3);
        check("inh_release_boot",  32'(boot),  32'd1);
        sof_valid = 1'b1;
        tick();
        sof_valid = 1'b0;
        check("boot_ignores_sof", 32'(state), 32'd3);

        reset = 1'b1;
        tick();
        check("rst2_state", 32'(state), 32'd0);
        check("rst2_boot",  32'(boot),  32'd0);
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
